// File: rtl/light_drv_pkg.sv
// Shared definitions for the traffic-phase counter and its lamp/display driver.
// Phase boundaries live here so that the producer and the consumer agree on them.
package light_drv_pkg;

  typedef enum logic [1:0] {
    PH_NS_G = 2'd0,
    PH_NS_Y = 2'd1,
    PH_EW_G = 2'd2,
    PH_EW_Y = 2'd3
  } phase_t;

  typedef enum logic {
    MODE_RUN   = 1'b0,
    MODE_FAULT = 1'b1
  } mode_t;

  // First count value of each later phase; Q_TURN is the turnaround count
  localparam int Q_NS_Y_BEGIN = 40;
  localparam int Q_EW_G_BEGIN = 45;
  localparam int Q_EW_Y_BEGIN = 65;
  localparam int Q_TURN       = 70;

  // Lamp heads as {red, yellow, green}
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  // Segments as {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/light_drv_seg7_dec.sv
// BCD digit to 7-segment pattern, {g,f,e,d,c,b,a} active-high.
// Codes above 9 are never produced by the driver and show blank.
module seg7_dec
  import light_drv_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Straight lookup of the segment pattern for one digit
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = 7'b0111111;
      4'd1: seg = 7'b0000110;
      4'd2: seg = 7'b1011011;
      4'd3: seg = 7'b1001111;
      4'd4: seg = 7'b1100110;
      4'd5: seg = 7'b1101101;
      4'd6: seg = 7'b1111101;
      4'd7: seg = 7'b0000111;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1101111;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/light_drv.sv
// Lamp and countdown-display driver fed by the traffic-phase counter.
// Watches the count/phase stream for illegal sequences and drops into a
// flashing-yellow safe mode until the counter resynchronises at count 0.
module light_drv
  import light_drv_pkg::*;
#(
  parameter int DW        = 7,
  parameter int BLINK_DIV = 25,
  parameter int SCAN_DIV  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] qout,
  input  logic [1:0]    state,
  output logic [2:0]    ns_light,
  output logic [2:0]    ew_light,
  output logic [DW-1:0] remain,
  output logic [6:0]    seg,
  output logic [1:0]    an,
  output logic          fault
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [DW-1:0] B_NS_Y = DW'(Q_NS_Y_BEGIN);
  localparam logic [DW-1:0] B_EW_G = DW'(Q_EW_G_BEGIN);
  localparam logic [DW-1:0] B_EW_Y = DW'(Q_EW_Y_BEGIN);
  localparam logic [DW-1:0] B_TURN = DW'(Q_TURN);

  mode_t         mode, mode_next;
  logic [DW-1:0] prev_q;
  logic          prev_vld;
  logic [BW-1:0] blink_cnt, blink_cnt_next;
  logic          blink, blink_next;
  logic [SW-1:0] scan_cnt, scan_cnt_next;
  logic [1:0]    an_next;

  phase_t        exp_state;
  logic [DW-1:0] phase_end;
  logic [2:0]    ns_run, ew_run;
  logic [DW:0]   prev_inc;
  logic          seq_ok, viol, resync, fault_entry;
  logic [DW-1:0] remain_calc;
  logic [3:0]    tens, ones;
  logic [6:0]    seg_tens, seg_ones, seg_run;

  // Decode the count into its expected phase code, phase end and RUN lamps
  always_comb begin
    exp_state = PH_NS_G;
    phase_end = B_TURN;
    ns_run    = RED;
    ew_run    = YEL;
    if (qout < B_NS_Y) begin
      exp_state = PH_NS_G; phase_end = B_NS_Y; ns_run = GRN; ew_run = RED;
    end else if (qout < B_EW_G) begin
      exp_state = PH_NS_Y; phase_end = B_EW_G; ns_run = YEL; ew_run = RED;
    end else if (qout < B_EW_Y) begin
      exp_state = PH_EW_G; phase_end = B_EW_Y; ns_run = RED; ew_run = GRN;
    end else if (qout < B_TURN) begin
      exp_state = PH_EW_Y; phase_end = B_TURN; ns_run = RED; ew_run = YEL;
    end
  end

  // Sequence monitor; the increment is one bit wider so a count cannot wrap into legality
  always_comb begin
    prev_inc    = {1'b0, prev_q} + (DW+1)'(1);
    seq_ok      = ({1'b0, qout} == prev_inc) || ((prev_q == B_TURN) && (qout == '0));
    viol        = (state != exp_state) || (qout > B_TURN) || (prev_vld && !seq_ok);
    resync      = (qout == '0) && (state == PH_NS_G) && !viol;
    fault_entry = (mode == MODE_RUN) && viol;
    mode_next   = mode;
    if (viol)
      mode_next = MODE_FAULT;
    else if ((mode == MODE_FAULT) && resync)
      mode_next = MODE_RUN;
  end

  // Blink and scan dividers; blink restarts lit whenever safe mode is entered
  always_comb begin
    blink_cnt_next = blink_cnt + BW'(1);
    blink_next     = blink;
    if (fault_entry) begin
      blink_cnt_next = '0;
      blink_next     = 1'b1;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt_next = '0;
      blink_next     = ~blink;
    end
    scan_cnt_next = scan_cnt + SW'(1);
    an_next       = an;
    if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt_next = '0;
      an_next       = ~an;
    end
  end

  // Countdown value split into tens and ones for the display
  always_comb begin
    remain_calc = phase_end - qout;
    tens        = 4'd0;
    ones        = 4'(remain_calc);
    if (remain_calc >= DW'(40)) begin
      tens = 4'd4; ones = 4'(remain_calc - DW'(40));
    end else if (remain_calc >= DW'(30)) begin
      tens = 4'd3; ones = 4'(remain_calc - DW'(30));
    end else if (remain_calc >= DW'(20)) begin
      tens = 4'd2; ones = 4'(remain_calc - DW'(20));
    end else if (remain_calc >= DW'(10)) begin
      tens = 4'd1; ones = 4'(remain_calc - DW'(10));
    end
  end

  seg7_dec u_tens (.bcd(tens), .seg(seg_tens));
  seg7_dec u_ones (.bcd(ones), .seg(seg_ones));

  // Pick the digit for the slot that becomes active this edge; leading zero blanked
  always_comb begin
    seg_run = seg_ones;
    if (an_next[1])
      seg_run = (tens == 4'd0) ? SEG_BLANK : seg_tens;
  end

  // Mode FSM, monitor history, dividers and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode      <= MODE_RUN;
      prev_q    <= '0;
      prev_vld  <= 1'b0;
      blink_cnt <= '0;
      blink     <= 1'b1;
      scan_cnt  <= '0;
      an        <= 2'b01;
      ns_light  <= RED;
      ew_light  <= RED;
      remain    <= '0;
      seg       <= SEG_BLANK;
      fault     <= 1'b0;
    end else begin
      mode      <= mode_next;
      prev_q    <= qout;
      prev_vld  <= 1'b1;
      blink_cnt <= blink_cnt_next;
      blink     <= blink_next;
      scan_cnt  <= scan_cnt_next;
      an        <= an_next;
      if (mode_next == MODE_FAULT) begin
        ns_light <= blink_next ? YEL : OFF;
        ew_light <= blink_next ? YEL : OFF;
        remain   <= '0;
        seg      <= SEG_DASH;
        fault    <= 1'b1;
      end else begin
        ns_light <= ns_run;
        ew_light <= ew_run;
        remain   <= remain_calc;
        seg      <= seg_run;
        fault    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_light_drv.sv
// Self-checking bench for light_drv: directed sweeps and violations plus
// randomized count/phase streams, all checked against a behavioural model.
module tb_light_drv;

  localparam int DW        = 7;
  localparam int BLINK_DIV = 25;
  localparam int SCAN_DIV  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] qout;
  logic [1:0]    state;
  logic [2:0]    ns_light, ew_light;
  logic [DW-1:0] remain;
  logic [6:0]    seg;
  logic [1:0]    an;
  logic          fault;

  int checkCount = 0;
  int failCount  = 0;

  // Reference model state
  bit mFault;
  bit mPrevVld;
  int mPrev;
  int mK;
  int mEdges;
  int curQ;

  logic [6:0] segTab [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111};

  light_drv #(.DW(DW), .BLINK_DIV(BLINK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .qout(qout), .state(state),
    .ns_light(ns_light), .ew_light(ew_light), .remain(remain),
    .seg(seg), .an(an), .fault(fault)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  function automatic int legalState(input int q);
    if (q < 40) return 0;
    if (q < 45) return 1;
    if (q < 65) return 2;
    if (q < 70) return 3;
    return 0;
  endfunction

  function automatic int phaseEnd(input int q);
    if (q < 40) return 40;
    if (q < 45) return 45;
    if (q < 65) return 65;
    return 70;
  endfunction

  function automatic int nsLamp(input int q);
    if (q < 40) return 1;
    if (q < 45) return 2;
    return 4;
  endfunction

  function automatic int ewLamp(input int q);
    if (q < 45) return 4;
    if (q < 65) return 1;
    return 2;
  endfunction

  // Single point for every comparison
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mFault   = 1'b0;
    mPrevVld = 1'b0;
    mPrev    = 0;
    mK       = 0;
    mEdges   = 0;
  endtask

  // One clock edge of the specified behaviour
  task automatic modelStep(input int q, input int s);
    bit viol;
    viol = (s != legalState(q)) || (q > 70) ||
           (mPrevVld && !((q == mPrev + 1) || (mPrev == 70 && q == 0)));
    if (viol) begin
      if (!mFault) begin
        mFault = 1'b1;
        mK     = 0;
      end else begin
        mK++;
      end
    end else if (mFault) begin
      if (q == 0 && s == 0) mFault = 1'b0;
      else mK++;
    end
    mPrev    = q;
    mPrevVld = 1'b1;
    mEdges++;
  endtask

  task automatic compareAll(input int q);
    int expAn, expRem, expLamp, expSeg, t, o;
    expAn = ((mEdges / SCAN_DIV) % 2 == 1) ? 2 : 1;
    checkOutput("an", an, expAn);
    if (mFault) begin
      expLamp = ((mK / BLINK_DIV) % 2 == 0) ? 2 : 0;
      checkOutput("fault", fault, 1);
      checkOutput("ns_blink", ns_light, expLamp);
      checkOutput("ew_blink", ew_light, expLamp);
      checkOutput("remain_f", remain, 0);
      checkOutput("seg_dash", seg, 7'b1000000);
    end else begin
      expRem = phaseEnd(q) - q;
      t = expRem / 10;
      o = expRem % 10;
      if (expAn == 2) expSeg = (t == 0) ? 0 : segTab[t];
      else expSeg = segTab[o];
      checkOutput("fault", fault, 0);
      checkOutput("ns_light", ns_light, nsLamp(q));
      checkOutput("ew_light", ew_light, ewLamp(q));
      checkOutput("remain", remain, expRem);
      checkOutput("seg", seg, expSeg);
    end
  endtask

  task automatic applyStimulus(input int q, input int s);
    @(negedge clk);
    qout  = DW'(q);
    state = 2'(s);
    curQ  = q;
    @(posedge clk);
    modelStep(q, s);
    #1;
    compareAll(q);
  endtask

  task automatic sweep(input int from, input int to);
    for (int q = from; q <= to; q++) applyStimulus(q, legalState(q));
  endtask

  // Assert reset between edges, check the all-red state, release off-edge
  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_ns", ns_light, 3'b100);
    checkOutput("rst_ew", ew_light, 3'b100);
    checkOutput("rst_remain", remain, 0);
    checkOutput("rst_fault", fault, 0);
    checkOutput("rst_seg", seg, 0);
    checkOutput("rst_an", an, 2'b01);
    modelReset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    int nq;
    rst_n = 1'b1;
    qout  = '0;
    state = 2'd0;
    curQ  = 0;
    modelReset();

    pulseReset();
    $display("[TB] legal sweep");
    sweep(0, 70);
    sweep(0, 70);
    applyStimulus(0, 0);

    $display("[TB] skip violation 12 -> 14");
    sweep(1, 12);
    applyStimulus(14, legalState(14));
    sweep(15, 70);
    applyStimulus(0, 0);

    $display("[TB] state mismatch at 50");
    sweep(1, 49);
    applyStimulus(50, 0);
    sweep(51, 70);
    applyStimulus(0, 0);

    $display("[TB] out of range 71");
    sweep(1, 70);
    applyStimulus(71, 0);
    applyStimulus(70, 0);
    applyStimulus(0, 0);

    $display("[TB] bad turnaround 70 -> 1");
    sweep(1, 70);
    applyStimulus(1, 0);
    sweep(2, 70);
    applyStimulus(0, 0);

    $display("[TB] randomized stream");
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 39);
      if (r == 0) begin
        nq = $urandom_range(0, 75);
        applyStimulus(nq, legalState(nq));
      end else if (r == 1) begin
        nq = (curQ >= 70) ? 0 : curQ + 1;
        applyStimulus(nq, $urandom_range(0, 3));
      end else begin
        nq = (curQ >= 70) ? 0 : curQ + 1;
        applyStimulus(nq, legalState(nq));
      end
    end

    $display("[TB] mid-fault reset");
    applyStimulus(20, 3);
    applyStimulus(21, 0);
    checkOutput("in_fault", fault, 1);
    pulseReset();
    sweep(33, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
